// File: rtl/adxl_pkg.sv
// adxl_pkg: shared constants and FSM state type for the ADXL362 transaction
// scheduler. The DEVID constants exist only when ADXL_ID_CHECK_EN is defined.
package adxl_pkg;

    // ADXL362 register map (subset used by the scheduler)
    localparam logic [7:0] ADXL_REG_XDATA_L    = 8'h0E;
    localparam logic [7:0] ADXL_REG_SOFT_RESET = 8'h1F;
    localparam logic [7:0] ADXL_REG_FILTER_CTL = 8'h2C;
    localparam logic [7:0] ADXL_REG_POWER_CTL  = 8'h2D;

    // SPI command bytes
    localparam logic [7:0] ADXL_CMD_WRITE = 8'h0A;
    localparam logic [7:0] ADXL_CMD_READ  = 8'h0B;

    // Register values
    localparam logic [7:0] ADXL_SRST_CODE   = 8'h52;
    localparam logic [7:0] ADXL_PWR_MEASURE = 8'h02;

`ifdef ADXL_ID_CHECK_EN
    localparam logic [7:0] ADXL_REG_DEVID = 8'h00;
    localparam logic [7:0] ADXL_DEVID_VAL = 8'hAD;
`endif

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SRST_WR   = 4'd1,
        ST_SRST_WAIT = 4'd2,
        ST_ID_RD     = 4'd3,
        ST_FILT_WR   = 4'd4,
        ST_PWR_WR    = 4'd5,
        ST_RUN_WAIT  = 4'd6,
        ST_RD_XY     = 4'd7,
        ST_PUBLISH   = 4'd8,
        ST_ERR       = 4'd9
    } adxl_state_e;

    // States that own an SPI transaction (request, ack, done)
    function automatic logic is_txn_state(input adxl_state_e s);
        return (s == ST_SRST_WR) || (s == ST_ID_RD) || (s == ST_FILT_WR) ||
               (s == ST_PWR_WR)  || (s == ST_RD_XY);
    endfunction

endpackage

// File: rtl/adxl_rate_tick.sv
// adxl_rate_tick: sample-rate period counter with a 1-deep pending flag.
// The counter only runs while 'run' is high and restarts from zero each time
// 'run' rises. A tick that finds the flag already set (and not being taken in
// the same cycle) is dropped and latches the sticky overrun flag.
module adxl_rate_tick #(
    parameter int PERIOD = 40000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic take,
    output logic pending,
    output logic overrun
);

    localparam int CNT_W = $clog2(PERIOD + 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = run && (cnt == CNT_W'(PERIOD - 1));

    // Period counter: held at zero while stopped, wraps on each tick
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Pending flag and sticky overrun; a take in the tick cycle frees the slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (!run) begin
            pending <= 1'b0;
        end else begin
            if (tick) begin
                pending <= 1'b1;
            end else if (take) begin
                pending <= 1'b0;
            end
            if (tick && pending && !take) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/adxl_txn_sched.sv
// adxl_txn_sched: owns the ADXL362 SPI transaction engine. Runs soft reset,
// settle wait, optional DEVID check, FILTER_CTL and POWER_CTL writes, then
// periodic 4-byte XDATA_L..YDATA_H burst reads published as x_raw/y_raw.
// Optional feature macro: ADXL_ID_CHECK_EN (adds the DEVID read state).
//
// Engine handshake: txn_req rises with rw/addr/wdata/len already valid and
// all of them hold until the engine returns a one-cycle txn_ack; txn_req
// drops the cycle after txn_ack. Read bytes then arrive as rd_valid/rd_data
// strobes and the transaction ends with a one-cycle txn_done. A request is
// never withdrawn once raised (except by rst_n).
module adxl_txn_sched
    import adxl_pkg::*;
#(
    parameter int         CLK_HZ         = 4000000,
    parameter int         SAMPLE_HZ      = 100,
    parameter int         SRST_WAIT_CYC  = 2000,
    parameter logic [7:0] FILTER_CTL_VAL = 8'h13,
    parameter int         TIMEOUT_CYC    = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        txn_req,
    input  logic        txn_ack,
    output logic        txn_rw,
    output logic [7:0]  txn_addr,
    output logic [7:0]  txn_wdata,
    output logic [2:0]  txn_len,
    input  logic        rd_valid,
    input  logic [7:0]  rd_data,
    input  logic        txn_done,
    output logic [15:0] x_raw,
    output logic [15:0] y_raw,
    output logic        xy_valid,
    output logic        init_done,
    output logic        err,
    output logic        overrun,
    output logic [3:0]  dbg_state
);

    localparam int TICK_PERIOD = CLK_HZ / SAMPLE_HZ;
    localparam int WAIT_W      = $clog2(SRST_WAIT_CYC + 1);
    localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

    adxl_state_e       state;
    adxl_state_e       state_nx;
    logic              acked;
    logic [TO_W-1:0]   to_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]        rd_byte [4];
    logic [2:0]        byte_cnt;
    logic [7:0]        txn_cmd;
    logic              in_txn;
    logic              txn_end;
    logic              to_expired;
    logic              wait_over;
    logic              burst_full;
    logic              take_pending;
    logic              tick_pending;
`ifdef ADXL_ID_CHECK_EN
    logic              id_bad;
`endif

    assign in_txn     = is_txn_state(state);
    assign txn_end    = in_txn && acked && txn_done;
    assign to_expired = in_txn && acked && !txn_done && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign wait_over  = (wait_cnt == WAIT_W'(SRST_WAIT_CYC - 1));
    assign burst_full = (byte_cnt == 3'd4);
    assign take_pending = (state == ST_RUN_WAIT) && (state_nx == ST_RD_XY);
    assign dbg_state  = state;
`ifdef ADXL_ID_CHECK_EN
    assign id_bad     = (byte_cnt == 3'd0) || (rd_byte[0] != ADXL_DEVID_VAL);
`endif

    adxl_rate_tick #(
        .PERIOD (TICK_PERIOD)
    ) u_rate_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (init_done),
        .take    (take_pending),
        .pending (tick_pending),
        .overrun (overrun)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Ack tracking and ack-to-done timeout counter
    always_ff @(posedge clk) begin
        if (!rst_n || !in_txn || txn_end) begin
            acked  <= 1'b0;
            to_cnt <= '0;
        end else if (!acked && txn_ack) begin
            acked  <= 1'b1;
            to_cnt <= '0;
        end else if (acked) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Post-soft-reset settle timer
    always_ff @(posedge clk) begin
        if (!rst_n || (state != ST_SRST_WAIT)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Read byte capture: slots 0..3 in arrival order, extra bytes ignored
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            for (int i = 0; i < 4; i++) begin
                rd_byte[i] <= '0;
            end
        end else if (in_txn && !acked && txn_ack) begin
            byte_cnt <= '0;
        end else if (in_txn && acked && txn_rw && rd_valid && (byte_cnt < 3'd4)) begin
            rd_byte[byte_cnt[1:0]] <= rd_data;
            byte_cnt               <= byte_cnt + 3'd1;
        end
    end

    // Sample registers: load on a complete burst, hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_raw <= '0;
            y_raw <= '0;
        end else if ((state == ST_RD_XY) && txn_end && burst_full) begin
            x_raw <= {rd_byte[1], rd_byte[0]};
            y_raw <= {rd_byte[3], rd_byte[2]};
        end
    end

    // Next-state logic; ERR is terminal until rst_n, IDLE implies err=0
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (enable) state_nx = ST_SRST_WR;
            end
            ST_SRST_WR: begin
                if (to_expired)   state_nx = ST_ERR;
                else if (txn_end) state_nx = enable ? ST_SRST_WAIT : ST_IDLE;
            end
            ST_SRST_WAIT: begin
                if (!enable) begin
                    state_nx = ST_IDLE;
                end else if (wait_over) begin
`ifdef ADXL_ID_CHECK_EN
                    state_nx = ST_ID_RD;
`else
                    state_nx = ST_FILT_WR;
`endif
                end
            end
`ifdef ADXL_ID_CHECK_EN
            ST_ID_RD: begin
                if (to_expired)   state_nx = ST_ERR;
                else if (txn_end) state_nx = id_bad ? ST_ERR : (enable ? ST_FILT_WR : ST_IDLE);
            end
`endif
            ST_FILT_WR: begin
                if (to_expired)   state_nx = ST_ERR;
                else if (txn_end) state_nx = enable ? ST_PWR_WR : ST_IDLE;
            end
            ST_PWR_WR: begin
                if (to_expired)   state_nx = ST_ERR;
                else if (txn_end) state_nx = enable ? ST_RUN_WAIT : ST_IDLE;
            end
            ST_RUN_WAIT: begin
                if (!enable)          state_nx = ST_IDLE;
                else if (tick_pending) state_nx = ST_RD_XY;
            end
            ST_RD_XY: begin
                if (to_expired)      state_nx = ST_ERR;
                else if (txn_end)    state_nx = burst_full ? ST_PUBLISH : (enable ? ST_RUN_WAIT : ST_IDLE);
            end
            ST_PUBLISH: begin
                state_nx = enable ? ST_RUN_WAIT : ST_IDLE;
            end
            ST_ERR: begin
                state_nx = ST_ERR;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Outputs: request fields are a pure function of state, so they stay put until ack
    always_comb begin
        txn_cmd   = ADXL_CMD_WRITE;
        txn_addr  = 8'h00;
        txn_wdata = 8'h00;
        txn_len   = 3'd0;
        case (state)
            ST_SRST_WR: begin
                txn_addr  = ADXL_REG_SOFT_RESET;
                txn_wdata = ADXL_SRST_CODE;
            end
`ifdef ADXL_ID_CHECK_EN
            ST_ID_RD: begin
                txn_cmd  = ADXL_CMD_READ;
                txn_addr = ADXL_REG_DEVID;
                txn_len  = 3'd1;
            end
`endif
            ST_FILT_WR: begin
                txn_addr  = ADXL_REG_FILTER_CTL;
                txn_wdata = FILTER_CTL_VAL;
            end
            ST_PWR_WR: begin
                txn_addr  = ADXL_REG_POWER_CTL;
                txn_wdata = ADXL_PWR_MEASURE;
            end
            ST_RD_XY: begin
                txn_cmd  = ADXL_CMD_READ;
                txn_addr = ADXL_REG_XDATA_L;
                txn_len  = 3'd4;
            end
            default: begin
                txn_cmd = ADXL_CMD_WRITE;
            end
        endcase
        txn_req   = in_txn && !acked;
        txn_rw    = (txn_cmd == ADXL_CMD_READ);
        init_done = (state == ST_RUN_WAIT) || (state == ST_RD_XY) || (state == ST_PUBLISH);
        err       = (state == ST_ERR);
        xy_valid  = (state == ST_PUBLISH);
    end

endmodule

// File: tb/tb_adxl_txn_sched.sv
// tb_adxl_txn_sched: directed bench for adxl_txn_sched with a behavioural SPI
// engine model, expected-transaction and expected-sample queues, and monitors
// that pop and compare whenever the DUT issues a request or publishes.
module tb_adxl_txn_sched;

    localparam int         CLK_HZ    = 4000000;
    localparam int         SAMPLE_HZ = 20000;
    localparam int         PERIOD    = CLK_HZ / SAMPLE_HZ;   // 200 cycles
    localparam int         SRST_WAIT = 2000;
    localparam int         TIMEOUT   = 1024;
    localparam logic [7:0] FILT_VAL  = 8'h13;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        txn_req;
    logic        txn_ack;
    logic        txn_rw;
    logic [7:0]  txn_addr;
    logic [7:0]  txn_wdata;
    logic [2:0]  txn_len;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        txn_done;
    logic [15:0] x_raw;
    logic [15:0] y_raw;
    logic        xy_valid;
    logic        init_done;
    logic        err;
    logic        overrun;
    logic [3:0]  dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    adxl_txn_sched #(
        .CLK_HZ         (CLK_HZ),
        .SAMPLE_HZ      (SAMPLE_HZ),
        .SRST_WAIT_CYC  (SRST_WAIT),
        .FILTER_CTL_VAL (FILT_VAL),
        .TIMEOUT_CYC    (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .txn_req   (txn_req),
        .txn_ack   (txn_ack),
        .txn_rw    (txn_rw),
        .txn_addr  (txn_addr),
        .txn_wdata (txn_wdata),
        .txn_len   (txn_len),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .txn_done  (txn_done),
        .x_raw     (x_raw),
        .y_raw     (y_raw),
        .xy_valid  (xy_valid),
        .init_done (init_done),
        .err       (err),
        .overrun   (overrun),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [19:0] exp_q[$];      // {rw, addr, wdata, len}
    logic [31:0] exp_xy_q[$];   // {x_raw, y_raw}
    int n_vec = 0;
    int n_err = 0;
    int n_pub = 0;
    int n_done = 0;
    int pub_cyc[$];
    int srst_done_cyc = 0;
    int filt_req_cyc = 0;
    int last_ack_cyc = 0;
    int err_cyc = 0;
    logic [7:0] last_done_addr = 8'h00;

    // engine model controls
    int         n_bytes = 4;
    logic [7:0] burst [4];
    logic [7:0] id_byte = 8'hAD;
    int         stall_ack = 0;
    bit         hang_en = 0;
    logic [7:0] hang_addr = 8'h2C;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] mk_txn(input logic rw, input logic [7:0] a,
                                           input logic [7:0] w, input logic [2:0] l);
        return {rw, a, w, l};
    endfunction

    task automatic push_init(input bit with_pwr);
        exp_q.push_back(mk_txn(1'b0, 8'h1F, 8'h52, 3'd0));
`ifdef ADXL_ID_CHECK_EN
        exp_q.push_back(mk_txn(1'b1, 8'h00, 8'h00, 3'd1));
`endif
        exp_q.push_back(mk_txn(1'b0, 8'h2C, FILT_VAL, 3'd0));
        if (with_pwr) exp_q.push_back(mk_txn(1'b0, 8'h2D, 8'h02, 3'd0));
    endtask

    task automatic push_burst(input logic [15:0] x, input logic [15:0] y, input bit publish);
        exp_q.push_back(mk_txn(1'b1, 8'h0E, 8'h00, 3'd4));
        if (publish) exp_xy_q.push_back({x, y});
    endtask

    task automatic set_burst(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input int nb);
        burst[0] = b0; burst[1] = b1; burst[2] = b2; burst[3] = b3;
        n_bytes  = nb;
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_pub(input int target, input int bound);
        int k = 0;
        while (n_pub < target && k < bound) begin @(negedge clk); k++; end
        check("wait_publish", 32'(n_pub >= target), 32'd1);
    endtask

    task automatic wait_done(input int target, input int bound);
        int k = 0;
        while (n_done < target && k < bound) begin @(negedge clk); k++; end
        check("wait_txn_done", 32'(n_done >= target), 32'd1);
    endtask

    task automatic wait_init(input int bound);
        int k = 0;
        while (!init_done && k < bound) begin @(negedge clk); k++; end
        check("wait_init_done", 32'(init_done), 32'd1);
    endtask

    task automatic wait_err(input int bound);
        int k = 0;
        while (!err && k < bound) begin @(negedge clk); k++; end
        check("wait_err", 32'(err), 32'd1);
    endtask

    // ---------------- SPI engine model ----------------
    initial begin : engine
        logic [7:0] addr_l;
        logic       rw_l;
        int         nb;
        txn_ack  = 1'b0;
        txn_done = 1'b0;
        rd_valid = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && txn_req) begin
                addr_l = txn_addr;
                rw_l   = txn_rw;
                if (stall_ack > 0) begin
                    repeat (stall_ack) @(negedge clk);
                    stall_ack = 0;
                end
                repeat (2) @(negedge clk);
                txn_ack      = 1'b1;
                last_ack_cyc = cyc + 1;
                @(negedge clk);
                txn_ack = 1'b0;
                nb = 0;
                if (rw_l) begin
                    nb = (addr_l == 8'h00) ? 1 : n_bytes;
                    for (int i = 0; i < nb; i++) begin
                        rd_valid = 1'b1;
                        rd_data  = (addr_l == 8'h00) ? id_byte : burst[i];
                        @(negedge clk);
                    end
                    rd_valid = 1'b0;
                end
                if (hang_en && addr_l == hang_addr) begin
                    while (rst_n) @(negedge clk);
                end else begin
                    repeat (19 - nb) @(negedge clk);
                    txn_done       = 1'b1;
                    last_done_addr = addr_l;
                    if (addr_l == 8'h1F) srst_done_cyc = cyc + 1;
                    n_done++;
                    @(negedge clk);
                    txn_done = 1'b0;
                end
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin : txn_monitor
        logic        prev_req = 1'b0;
        logic [19:0] snap = '0;
        logic [19:0] cur;
        logic        stable_bad = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                cur = {txn_rw, txn_addr, txn_wdata, txn_len};
                if (txn_ack) check("req_drop_after_ack", 32'(txn_req), 32'd0);
                if (txn_req && !prev_req) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL txn_unexpected: got %h, expected no request", cur);
                    end else begin
                        check("txn_fields", 32'(cur), 32'(exp_q.pop_front()));
                    end
                    snap = cur;
                    stable_bad = 1'b0;
                    if (txn_addr == 8'h2C) filt_req_cyc = cyc;
                end else if (txn_req && cur != snap) begin
                    stable_bad = 1'b1;
                end
                if (!txn_req && prev_req) check("req_stable", 32'(stable_bad), 32'd0);
                prev_req = txn_req;
            end
        end
    end

    initial begin : out_monitor
        logic prev_xy = 1'b0;
        logic prev_init = 1'b0;
        logic prev_err = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                prev_xy = 1'b0; prev_init = 1'b0; prev_err = 1'b0;
            end else begin
                if (xy_valid) begin
                    check("xy_latency_done", 32'(txn_done), 32'd1);
                    check("xy_one_cycle", 32'(prev_xy), 32'd0);
                    if (exp_xy_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL xy_unexpected: got %h, expected no publish", {x_raw, y_raw});
                    end else begin
                        check("xy_data", {x_raw, y_raw}, exp_xy_q.pop_front());
                    end
                    pub_cyc.push_back(cyc);
                    n_pub++;
                end
                if (init_done && !prev_init)
                    check("init_rise_on_pwr_done", {23'd0, txn_done, last_done_addr}, {23'd0, 1'b1, 8'h2D});
                if (err && !prev_err) err_cyc = cyc;
                prev_xy = xy_valid; prev_init = init_done; prev_err = err;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        int tgt;
        rst_n  = 1'b0;
        enable = 1'b0;
        set_burst(8'h34, 8'h12, 8'hF0, 8'hFF, 4);
        repeat (5) @(negedge clk);

        // reset state
        check("rst_txn_req", 32'(txn_req), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_xy_valid", 32'(xy_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_xy_raw", {x_raw, y_raw}, 32'd0);

        // init sequence
        push_init(1'b1);
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_init(6000);
        check("srst_gap_ge_wait", 32'((filt_req_cyc - srst_done_cyc) >= SRST_WAIT), 32'd1);

        // two full bursts, one period apart
        push_burst(16'h1234, 16'hFFF0, 1'b1);
        wait_pub(1, 600);
        push_burst(16'h1234, 16'hFFF0, 1'b1);
        wait_pub(2, 600);
        check("x_raw_after_burst", 32'(x_raw), 32'h1234);
        check("y_raw_after_burst", 32'(y_raw), 32'hFFF0);
        check("burst_period", 32'(pub_cyc[1] - pub_cyc[0]), 32'(PERIOD));

        // short burst: two bytes only, nothing published, outputs hold
        set_burst(8'h11, 8'h22, 8'h00, 8'h00, 2);
        push_burst(16'h0, 16'h0, 1'b0);
        tgt = n_done + 1;
        wait_done(tgt, 600);
        repeat (10) @(negedge clk);
        check("short_x_hold", 32'(x_raw), 32'h1234);
        check("short_y_hold", 32'(y_raw), 32'hFFF0);
        check("short_no_publish", 32'(n_pub), 32'd2);

        // next tick reads again
        set_burst(8'h78, 8'h56, 8'h00, 8'h80, 4);
        push_burst(16'h5678, 16'h8000, 1'b1);
        wait_pub(3, 600);
        check("overrun_clear_before", 32'(overrun), 32'd0);

        // overrun: ack stalled past two periods, exactly one extra read follows
        set_burst(8'hBC, 8'h9A, 8'h01, 8'h00, 4);
        stall_ack = 450;
        push_burst(16'h9ABC, 16'h0001, 1'b1);
        push_burst(16'h9ABC, 16'h0001, 1'b1);
        wait_pub(5, 1500);
        enable = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        repeat (3) @(negedge clk);
        check("disable_init_low", 32'(init_done), 32'd0);
        check("disable_req_low", 32'(txn_req), 32'd0);

        // timeout: FILTER_CTL write acked but never completed
        hang_en   = 1'b1;
        hang_addr = 8'h2C;
        push_init(1'b0);
        enable = 1'b1;
        wait_err(6000);
        check("timeout_req_low", 32'(txn_req), 32'd0);
        check("timeout_init_low", 32'(init_done), 32'd0);
        check("timeout_cycles", 32'(err_cyc - last_ack_cyc), 32'(TIMEOUT));
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("err_sticky_en0", 32'(err), 32'd1);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        check("err_sticky_en1", 32'(err), 32'd1);
        check("err_req_low", 32'(txn_req), 32'd0);
        enable = 1'b0;
        rst_n  = 1'b0;
        hang_en = 1'b0;
        repeat (3) @(negedge clk);
        check("err_cleared_by_rst", 32'(err), 32'd0);
        check("overrun_cleared_by_rst", 32'(overrun), 32'd0);
        rst_n = 1'b1;

`ifdef ADXL_ID_CHECK_EN
        // wrong DEVID: error, no FILTER_CTL write
        id_byte = 8'hAC;
        exp_q.push_back(mk_txn(1'b0, 8'h1F, 8'h52, 3'd0));
        exp_q.push_back(mk_txn(1'b1, 8'h00, 8'h00, 3'd1));
        enable = 1'b1;
        wait_err(6000);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        check("id_bad_no_filter", 32'(exp_q.size()), 32'd0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // correct DEVID: normal init
        id_byte = 8'hAD;
        push_init(1'b1);
        enable = 1'b1;
        wait_init(6000);
        check("id_ok_err_low", 32'(err), 32'd0);
        enable = 1'b0;
`endif

        repeat (20) @(negedge clk);
        check("txn_queue_empty", 32'(exp_q.size()), 32'd0);
        check("xy_queue_empty", 32'(exp_xy_q.size()), 32'd0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #(2000000);
        n_vec++;
        n_err++;
        $display("FAIL watchdog: got cycle %0d, expected completion earlier", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "simulation time limit reached");
    end

endmodule
